spi_adc_capture: RTL

- Parametrised, fully synchronous SPI capture engine for the PmodMIC3 ADC front end, and for up to NUM_CH ADCs that share CS/SCLK and have separate MISO lines.
- Generates its own chip-select at SAMPLE_HZ and a divided SCLK, both derived from CLK, and shifts in FRAME_BITS per channel.
- Outputs DATA_BITS per channel with a single-cycle valid strobe, an optional signed conversion and a frame-error flag.
- Feeds the downstream audio-effects and scope pipeline.

---
 rtl/spi_adc_capture.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_adc_capture.sv
`default_nettype none
// ============================================================================
// Module   : spi_adc_capture
// Purpose  : SPI capture engine for PmodMIC3-style ADCs. It generates its own
//            frame-rate chip select and a divided SCLK, and shifts FRAME_BITS
//            per frame from up to NUM_CH ADCs. The ADCs share CS/SCLK and each
//            has its own MISO line. It presents DATA_BITS per channel with a
//            one-cycle valid strobe and a frame-error flag.
// Ports    : CLK          - system clock, posedge
//            RST_N        - asynchronous active-low reset, released synchronously
//            en           - capture enable
//            MISO         - serial data, one bit per ADC
//            cs_n         - chip select, active low
//            sclk         - serial clock, idles high
//            sample       - channel c at [c*DATA_BITS +: DATA_BITS]
//            sample_valid - one-cycle pulse when sample updates
//            frame_err    - leading (non-payload) bits of last frame nonzero
// Revision : 1.0 - initial release
// ============================================================================
module spi_adc_capture #(
  parameter int CLK_HZ     = 100000000,
  parameter int SAMPLE_HZ  = 20000,
  parameter int SCLK_DIV   = 50,
  parameter int FRAME_BITS = 16,
  parameter int DATA_BITS  = 12,
  parameter int NUM_CH     = 1,
  parameter int SIGNED_OUT = 0
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        en,
  input  logic [NUM_CH-1:0]           MISO,
  output logic                        cs_n,
  output logic                        sclk,
  output logic [NUM_CH*DATA_BITS-1:0] sample,
  output logic                        sample_valid,
  output logic                        frame_err
);

  localparam int C_SAMP_DIV = CLK_HZ / SAMPLE_HZ;
  localparam int C_CNT_W    = (C_SAMP_DIV > 1) ? $clog2(C_SAMP_DIV) : 1;
  localparam int C_DIV_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int C_BIT_W    = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  localparam logic [C_CNT_W-1:0]   C_CNT_LAST  = C_CNT_W'(C_SAMP_DIV - 1);
  localparam logic [C_DIV_W-1:0]   C_DIV_LAST  = C_DIV_W'(SCLK_DIV - 1);
  localparam logic [C_BIT_W-1:0]   C_BIT_LAST  = C_BIT_W'(FRAME_BITS - 1);
  // Offset-binary to two's complement is a flip of the payload MSB.
  localparam logic [DATA_BITS-1:0] C_SIGN_MASK =
    (SIGNED_OUT != 0) ? (DATA_BITS'(1) << (DATA_BITS - 1)) : '0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LEAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_TAIL  = 2'd3;

  // Reject parameter sets whose frame does not fit in one sample period.
  if (((2 * FRAME_BITS + 2) * SCLK_DIV >= C_SAMP_DIV) ||
      (DATA_BITS > FRAME_BITS) || (SCLK_DIV < 1)) begin : g_cfg_check
    $fatal(1, "spi_adc_capture: invalid parameter combination");
  end

  logic [C_CNT_W-1:0]          cnt_q, cnt_d;
  logic [C_DIV_W-1:0]          div_q, div_d;
  logic [C_BIT_W-1:0]          bit_q, bit_d;
  logic [1:0]                  state_q, state_d;
  logic                        cs_n_q, cs_n_d;
  logic                        sclk_q, sclk_d;
  logic [NUM_CH*DATA_BITS-1:0] sample_q;
  logic                        sample_valid_q;
  logic                        frame_err_q;

  logic                        w_wrap;
  logic                        w_tick;
  logic                        w_shift;
  logic                        w_done;
  logic [NUM_CH*DATA_BITS-1:0] w_payload;
  logic [NUM_CH-1:0]           w_err;

  // Period counter: free-running while enabled and parked at 0 otherwise, so
  // a frame starts exactly one period after en rises.
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == C_CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign w_wrap = en && (cnt_q == C_CNT_LAST);
  assign w_tick = (div_q == C_DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    w_shift = 1'b0;
    w_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b1;
        div_d  = '0;
        bit_d  = '0;
        if (w_wrap) begin
          cs_n_d  = 1'b0;
          state_d = S_LEAD;
        end
      end
      S_LEAD: begin
        if (w_tick) begin
          div_d   = '0;
          sclk_d  = 1'b0;
          state_d = S_SHIFT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_tick) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          // Data is taken on the edge that drives sclk 0->1.
          if (!sclk_q) begin
            w_shift = 1'b1;
            bit_d   = bit_q + 1'b1;
            if (bit_q == C_BIT_LAST) begin
              state_d = S_TAIL;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_TAIL: begin
        if (w_tick) begin
          div_d   = '0;
          cs_n_d  = 1'b1;
          w_done  = 1'b1;
          state_d = S_IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b1;
      end
    endcase
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [FRAME_BITS-1:0] shift_q;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        shift_q <= '0;
      end else if (w_shift) begin
        shift_q <= (shift_q << 1) | FRAME_BITS'(MISO[c]);
      end
    end

    assign w_payload[c*DATA_BITS +: DATA_BITS] = shift_q[DATA_BITS-1:0] ^ C_SIGN_MASK;

    if (FRAME_BITS > DATA_BITS) begin : g_err
      assign w_err[c] = |shift_q[FRAME_BITS-1:DATA_BITS];
    end else begin : g_no_err
      assign w_err[c] = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q          <= '0;
      div_q          <= '0;
      bit_q          <= '0;
      state_q        <= S_IDLE;
      cs_n_q         <= 1'b1;
      sclk_q         <= 1'b1;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      div_q          <= div_d;
      bit_q          <= bit_d;
      state_q        <= state_d;
      cs_n_q         <= cs_n_d;
      sclk_q         <= sclk_d;
      sample_valid_q <= w_done;
      if (w_done) begin
        sample_q    <= w_payload;
        frame_err_q <= |w_err;
      end
    end
  end

  assign cs_n         = cs_n_q;
  assign sclk         = sclk_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign frame_err    = frame_err_q;

endmodule
`default_nettype wire
